tt_um_serial_word_tx: RTL
=========================

Name: tt_um_serial_word_tx

Overview:
- Parallel-to-serial word transmitter; the serializing counterpart of the team's serial shift-in receiver.
- Host loads a 32-bit word one byte at a time on ui_in, then issues start.
- Block shifts the word out MSB-first on a single pin, with a programmable bit period.
- Provides framing, per-bit strobe, busy and done outputs so the word can drive the receive-side shift register directly.

Parameters:
- WORD_BITS, 32, bits per transmitted word (must be a multiple of 8).
- DIV_W, 4, width of the clocks-per-bit divider field.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; ignored by logic.
- ui_in  input  8  write data byte.
- uio_in  input  8  [0]=wr (byte push), [1]=start, [3:2] unused, [7:4]=div (clocks-per-bit minus 1).
- uo_out  output  8  [0]=sdata, [1]=bit_strobe, [2]=frame, [3]=busy, [4]=done, [7:5]=0.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all uio pins are inputs).

Behaviour:
- Registers:
  - hold[WORD_BITS-1:0]: holding register.
  - shreg[WORD_BITS-1:0]: shift register.
  - bit_cnt: 5 bits for WORD_BITS=32.
  - div_cnt and div_lat: DIV_W bits each.
  - state: IDLE / SHIFT / DONE.
- Reset (async, rst_n=0): all registers 0, state=IDLE. uo_out=0 while reset is held and on release.
- IDLE:
  - wr=1 at an edge shifts a byte into hold: hold <= {hold[WORD_BITS-9:0], ui_in}. The first byte written ends up most significant after 4 writes.
  - start=1 at an edge loads shreg <= hold (value before any same-edge write), div_lat <= div, div_cnt <= div, bit_cnt <= WORD_BITS-1, and moves to SHIFT.
  - start and wr at the same edge: shreg takes the old hold, and hold also takes the write.
- SHIFT:
  - sdata = shreg[MSB]; frame=1; busy=1.
  - bit_strobe=1 in the cycle where div_cnt==0, i.e. the last cycle of each bit period.
  - At an edge with div_cnt!=0: div_cnt decrements.
  - At an edge with div_cnt==0 and bit_cnt!=0: shreg <<= 1 (zero fill), bit_cnt decrements, div_cnt <= div_lat.
  - At an edge with div_cnt==0 and bit_cnt==0: go to DONE.
  - Each bit is held exactly div_lat+1 cycles. frame is high for exactly WORD_BITS*(div_lat+1) cycles.
  - wr and start are ignored in SHIFT and DONE; hold is unchanged.
  - Changing uio_in[7:4] mid-word has no effect.
- DONE: lasts one cycle. done=1, busy=1, frame=0, sdata=0. Then unconditionally returns to IDLE.
- Outside SHIFT: sdata=0, bit_strobe=0.
- Output timing: all outputs are decoded from registered state (no ui_in/uio_in to uo_out combinational path). First data bit appears in the cycle after the start edge.
- Back-to-back words: start asserted in the first IDLE cycle after DONE is accepted. Minimum gap between frames is 2 cycles (DONE + the IDLE start edge).
- Reset mid-transfer: immediate abort. sdata/frame/busy drop to 0 asynchronously; hold is cleared; no done pulse is produced.
- Wrap-around: bit_cnt and div_cnt never underflow (guarded by the ==0 checks). More than 4 writes keeps only the last 4 bytes.

Test Plan:
- Reset: rst_n low 3 cycles with random inputs -> uo_out=0x00, uio_out=0x00, uio_oe=0x00. After release with no start, all outputs stay 0.
- Basic word, div=0: write 0xDE,0xAD,0xBE,0xEF, then start -> sdata over the next 32 cycles is 0xDEADBEEF MSB-first. frame=1 for 32 cycles, bit_strobe=1 every cycle, done=1 in cycle 33, busy falls in cycle 34.
- Divider, div=3: word 0x80000001 -> sdata=1 for cycles 1-4, 0 for cycles 5-124, 1 for cycles 125-128. bit_strobe on every 4th cycle (32 pulses), done in cycle 129.
- Busy lockout: during SHIFT, pulse wr with 0x55 and pulse start -> transmitted word is unchanged. Next start after DONE without new writes retransmits the original hold value.
- Simultaneous start+wr in IDLE: hold=0x12345678, start with wr and ui_in=0x9A -> sends 0x12345678. A following start sends 0x3456789A.
- Reset mid-word: assert rst_n low at bit 10 -> uo_out=0 immediately, no done pulse. After release, start without writes sends 0x00000000.

Source files
------------

// File: rtl/tt_um_serial_word_tx.sv
// rtl/tt_um_serial_word_tx.sv - byte-loaded word transmitter, MSB-first serial out with bit-period divider
module tt_um_serial_word_tx #(
    parameter int WORD_BITS = 32,
    parameter int DIV_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(WORD_BITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [WORD_BITS-1:0] hold;
    logic [WORD_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_lat;
    logic [1:0]           state;

    logic             wr;
    logic             start;
    logic [DIV_W-1:0] div;

    assign wr    = uio_in[0];
    assign start = uio_in[1];
    assign div   = uio_in[4 +: DIV_W];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[3:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            div_lat <= '0;
            state   <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // shreg samples hold before any same-edge byte push lands
                    if (wr) begin
                        hold <= {hold[WORD_BITS-9:0], ui_in};
                    end
                    if (start) begin
                        shreg   <= hold;
                        div_lat <= div;
                        div_cnt <= div;
                        bit_cnt <= CNT_W'(WORD_BITS - 1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (bit_cnt != '0) begin
                        shreg   <= {shreg[WORD_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                        div_cnt <= div_lat;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic sdata;
    logic bit_strobe;
    logic frame;
    logic busy;
    logic done;

    assign frame      = (state == SHIFT);
    assign sdata      = frame & shreg[WORD_BITS-1];
    assign bit_strobe = frame & (div_cnt == '0);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    assign uo_out  = {3'b000, done, busy, frame, bit_strobe, sdata};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
